// File: rtl/boid_frame_scheduler.sv
// Per-frame scheduler: copies boid positions into the display RAM after each VGA end-of-frame
// and arbitrates CPU write access to the BPUs. Optional macro BOID_FRAME_STATS_EN adds dropped_frames.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      screen_end,
  input  logic                      enable,
  input  logic                      cpu_req,
  output logic                      cpu_gnt,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  input  logic [9:0]                boid_x,
  input  logic [8:0]                boid_y,
  output logic                      switch_ram,
  output logic                      disp_we,
  output logic [ADDR_WIDTH-1:0]     disp_addr,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
`ifdef BOID_FRAME_STATS_EN
  ,
  output logic [15:0]               dropped_frames
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, WRITE, DONE} state_e;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  state_e                      state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0]   idx_q, idx_d;
  logic                        screen_end_q;
  logic                        pending_q, pending_d;
  logic                        cpu_gnt_q, cpu_gnt_d;
  logic [BITS_FOR_BOIDS-1:0]   boid_sel_q, boid_sel_d;
  logic                        switch_ram_q, switch_ram_d;
  logic                        disp_we_q, disp_we_d;
  logic [ADDR_WIDTH-1:0]       disp_addr_q, disp_addr_d;
  logic                        busy_q, busy_d;
  logic                        frame_done_q, frame_done_d;
  logic                        overrun_q, overrun_d;
  logic                        fe;
  logic                        drop;
  logic                        in_range;
  logic [ADDR_WIDTH-1:0]       pix_addr;

  assign fe       = screen_end & ~screen_end_q & enable;
  // y*640 as two shifts; widened first so the sum never truncates.
  assign pix_addr = (ADDR_WIDTH'(boid_y) << 9) + (ADDR_WIDTH'(boid_y) << 7) + ADDR_WIDTH'(boid_x);
  assign in_range = (int'(boid_x) < VIDEO_WIDTH) && (int'(boid_y) < VIDEO_HEIGHT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      screen_end_q <= 1'b1;
      pending_q    <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      boid_sel_q   <= '0;
      switch_ram_q <= 1'b0;
      disp_we_q    <= 1'b0;
      disp_addr_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      screen_end_q <= screen_end;
      pending_q    <= pending_d;
      cpu_gnt_q    <= cpu_gnt_d;
      boid_sel_q   <= boid_sel_d;
      switch_ram_q <= switch_ram_d;
      disp_we_q    <= disp_we_d;
      disp_addr_q  <= disp_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((fe | pending_q) & ~cpu_gnt_q) begin
          state_d   = CLEAR;
          pending_d = 1'b0;
        end else if (fe) begin
          if (pending_q) drop = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      CLEAR: begin
        drop    = fe;
        idx_d   = '0;
        state_d = READ;
      end
      READ: begin
        drop    = fe;
        state_d = WRITE;
      end
      WRITE: begin
        drop = fe;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      DONE: begin
        // Scan is over here, so a new edge is queued rather than lost.
        if (fe) begin
          if (pending_q) drop = 1'b1;
          else           pending_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    switch_ram_d = (state_d == CLEAR);
    busy_d       = (state_d == CLEAR) || (state_d == READ) || (state_d == WRITE);
    frame_done_d = (state_d == DONE);
    cpu_gnt_d    = (state_q == IDLE) && (state_d == IDLE) && cpu_req;
    boid_sel_d   = ((state_d == READ) || (state_d == WRITE)) ? idx_d : '0;
    overrun_d    = overrun_q | drop;
    disp_we_d    = 1'b0;
    disp_addr_d  = disp_addr_q;
    if (state_q == READ) begin
      disp_addr_d = pix_addr;
      disp_we_d   = in_range;
    end
  end

`ifdef BOID_FRAME_STATS_EN
  logic [15:0] dropped_q;

  always_ff @(posedge clock) begin
    if (!reset)                       dropped_q <= '0;
    else if (drop && dropped_q != '1) dropped_q <= dropped_q + 16'd1;
  end

  assign dropped_frames = dropped_q;
`endif

  assign cpu_gnt    = cpu_gnt_q;
  assign boid_sel   = boid_sel_q;
  assign switch_ram = switch_ram_q;
  assign disp_we    = disp_we_q;
  assign disp_addr  = disp_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Bench for boid_frame_scheduler: a frame-timeline model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_boid_frame_scheduler;
  localparam int N  = 4;
  localparam int AW = 19;

  logic          clock = 1'b0;
  logic          reset, screen_end, enable, cpu_req;
  logic          cpu_gnt, switch_ram, disp_we, busy, frame_done, overrun;
  logic [1:0]    boid_sel;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic [AW-1:0] disp_addr;
`ifdef BOID_FRAME_STATS_EN
  logic [15:0]   dropped_frames;
`endif

  logic [9:0] bx [N];
  logic [8:0] by [N];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;
  int  done_cnt = 0;

  boid_frame_scheduler dut (
    .clock(clock), .reset(reset), .screen_end(screen_end), .enable(enable),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .boid_sel(boid_sel),
    .boid_x(boid_x), .boid_y(boid_y), .switch_ram(switch_ram),
    .disp_we(disp_we), .disp_addr(disp_addr), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
`ifdef BOID_FRAME_STATS_EN
    , .dropped_frames(dropped_frames)
`endif
  );

  always #5 clock = ~clock;

  // BPU read mux stand-in.
  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame model: a scan is a timeline of offsets k since the accepted edge (k=1 clear,
  // even k read boid (k-2)/2, odd k>=3 write boid (k-3)/2, k=2N+2 frame done).
  bit m_active, m_prev_se, m_pending, m_gnt, m_ovr, m_we;
  int m_k, m_addr, m_drop;

  task automatic drop_frame();
    m_ovr = 1'b1;
    if (m_drop < 65535) m_drop++;
  endtask

  always @(posedge clock) begin : model
    bit fe;
    int idx;
    if (!reset) begin
      m_active = 0; m_k = 0; m_prev_se = 1; m_pending = 0; m_gnt = 0;
      m_ovr = 0; m_drop = 0; m_addr = 0; m_we = 0;
    end else begin
      fe = screen_end && !m_prev_se && enable;
      m_prev_se = screen_end;
      m_we = 0;
      if (m_active && m_k <= 2 * N + 1) begin
        if (fe) drop_frame();
        m_k++;
        if (m_k >= 3 && m_k % 2 == 1) begin
          idx    = (m_k - 3) / 2;
          m_addr = int'(by[idx]) * 640 + int'(bx[idx]);
          m_we   = (bx[idx] < 640) && (by[idx] < 480);
        end
      end else if (m_active) begin
        if (fe) begin
          if (m_pending) drop_frame();
          else           m_pending = 1;
        end
        m_active = 0; m_k = 0; m_gnt = 0;
      end else begin
        if ((fe || m_pending) && !m_gnt) begin
          m_active = 1; m_k = 1; m_pending = 0; m_gnt = 0;
        end else begin
          if (fe) begin
            if (m_pending) drop_frame();
            else           m_pending = 1;
          end
          m_gnt = cpu_req;
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    if (chk_en) begin
      check("switch_ram", switch_ram, (m_active && m_k == 1));
      check("busy", busy, (m_active && m_k >= 1 && m_k <= 2 * N + 1));
      check("frame_done", frame_done, (m_active && m_k == 2 * N + 2));
      check("boid_sel", boid_sel, (m_active && m_k >= 2 && m_k <= 2 * N + 1) ? (m_k - 2) / 2 : 0);
      check("disp_we", disp_we, m_we);
      check("disp_addr", disp_addr, m_addr);
      check("cpu_gnt", cpu_gnt, m_gnt);
      check("overrun", overrun, m_ovr);
`ifdef BOID_FRAME_STATS_EN
      check("dropped_frames", dropped_frames, m_drop);
`endif
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    reset = 0; screen_end = 0; enable = 1; cpu_req = 0;
    bx[0] = 10;  by[0] = 10;
    bx[1] = 0;   by[1] = 0;
    bx[2] = 639; by[2] = 479;
    bx[3] = 5;   by[3] = 1;
    step(1);
    chk_en = 1;
    check("rst_busy", busy, 0);
    check("rst_gnt", cpu_gnt, 0);
    check("rst_addr", disp_addr, 0);
    check("rst_overrun", overrun, 0);
    step(2);
    reset = 1;
    step(2);

    // Full frame scan
    screen_end = 1;
    step(1); check("scan_switch_t1", switch_ram, 1); check("scan_busy_t1", busy, 1);
    step(2); check("scan_we_t3", disp_we, 1); check("scan_addr_t3", disp_addr, 6410);
    step(2); check("scan_we_t5", disp_we, 1); check("scan_addr_t5", disp_addr, 0);
    step(2); check("scan_we_t7", disp_we, 1); check("scan_addr_t7", disp_addr, 307199);
    step(2); check("scan_we_t9", disp_we, 1); check("scan_addr_t9", disp_addr, 645);
    step(1); check("scan_done_t10", frame_done, 1); check("scan_busy_t10", busy, 0);
    step(2); screen_end = 0; step(2);

    // Out-of-range boid is skipped
    bx[2] = 640; by[2] = 0;
    screen_end = 1;
    step(5); check("oor_we_t5", disp_we, 1);
    step(2); check("oor_we_t7", disp_we, 0); check("oor_addr_t7", disp_addr, 640);
    step(2); check("oor_we_t9", disp_we, 1);
    step(1); check("oor_done_t10", frame_done, 1);
    bx[2] = 639; by[2] = 479;
    screen_end = 0; step(2);

    // Frame edge during CPU grant is deferred
    cpu_req = 1;
    step(1); check("cpu_gnt_on", cpu_gnt, 1);
    screen_end = 1;
    step(4); check("cpu_no_switch", switch_ram, 0); check("cpu_no_busy", busy, 0);
    cpu_req = 0;
    step(1); check("cpu_gnt_off_u1", cpu_gnt, 0); check("cpu_switch_u1", switch_ram, 0);
    step(1); check("cpu_switch_u2", switch_ram, 1);
    step(12); screen_end = 0; step(2);

    // Overrun: second edge mid-scan
    screen_end = 1;
    step(2); screen_end = 0;
    step(2); screen_end = 1;
    step(6); check("ovr_done_t10", frame_done, 1); check("ovr_flag", overrun, 1);
`ifdef BOID_FRAME_STATS_EN
    check("ovr_dropped", dropped_frames, 1);
`endif
    step(3); check("ovr_sticky", overrun, 1);
    screen_end = 0; step(2);

    // Reset mid-scan, screen_end left high afterwards
    screen_end = 1;
    step(5); reset = 0;
    step(1);
    check("rmid_busy", busy, 0); check("rmid_we", disp_we, 0);
    check("rmid_sel", boid_sel, 0); check("rmid_ovr", overrun, 0);
    reset = 1;
    step(5); check("rmid_no_scan", busy, 0);
    screen_end = 0; step(2);

    // Long screen_end: a single scan
    done_cnt = 0;
    screen_end = 1;
    step(20); screen_end = 0;
    step(5);
    check("long_one_scan", done_cnt, 1); check("long_no_ovr", overrun, 0);

    // Disabled edges are ignored
    enable = 0; screen_end = 1;
    step(4); check("dis_no_busy", busy, 0);
    screen_end = 0; enable = 1; step(2);

    // Pending frame survives enable going low
    cpu_req = 1;
    step(2); screen_end = 1;
    step(1); enable = 0; screen_end = 0;
    step(2); cpu_req = 0;
    step(2); check("pend_switch", switch_ram, 1);
    enable = 1;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/boid_frame_scheduler.md
Name: boid_frame_scheduler

Overview:
- Sequences the per-frame copy of boid positions from the BPU array into the boid display RAM.
- On each VGA end-of-frame it pulses a display RAM clear/swap, then walks boids 0..MAX_BOIDS-1, computing pixel addresses and issuing display writes.
- Arbitrates CPU write access to the BPUs, so positions are never updated mid-scan.
- Sits between the VGAController (screenEnd_out), the BPU read mux and RAM_resettable. It replaces ad-hoc frame-update logic in the top level.

Parameters:
- MAX_BOIDS, 4: number of BPU instances scanned per frame; must be ≥ 1.
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS) (minimum 1): width of boid_sel.
- VIDEO_WIDTH, 640: pixels per line; x must be below this.
- VIDEO_HEIGHT, 480: lines per frame; y must be below this.
- ADDR_WIDTH, 19: display RAM address width.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- screen_end  in  1  end-of-frame level from VGAController; may stay high for several cycles.
- enable  in  1  0 = ignore new frame edges; a scan already in progress completes.
- cpu_req  in  1  CPU requests BPU write access.
- cpu_gnt  out  1  CPU may write BPUs (gates CPU_all_boids_we).
- boid_sel  out  BITS_FOR_BOIDS  index of the boid driven onto boid_x/boid_y.
- boid_x  in  10  x of the selected boid; combinational mux output.
- boid_y  in  9  y of the selected boid.
- switch_ram  out  1  one-cycle clear/swap pulse to RAM_resettable.
- disp_we  out  1  display RAM write enable; write data is always 1.
- disp_addr  out  ADDR_WIDTH  display RAM write address.
- busy  out  1  scan in progress.
- frame_done  out  1  one-cycle pulse after the last boid is handled.
- overrun  out  1  sticky flag: a frame edge arrived while busy.

Behaviour:
- All outputs are registered.
- Reset values (reset == 0 at a clock edge): state IDLE; boid_sel, disp_addr, disp_we, switch_ram, busy, frame_done, overrun, cpu_gnt = 0; pending = 0; screen_end delay flop = 1, so a level already high at reset release is not treated as an edge.
- Edge detect: fe = screen_end & ~screen_end_q & enable.
- States: IDLE, CLEAR, READ, WRITE, DONE.
- IDLE:
  - If (fe | pending) & ~cpu_gnt: go to CLEAR and clear pending.
  - If fe & cpu_gnt: set pending; stay in IDLE.
  - Otherwise, cpu_gnt follows cpu_req with one cycle of latency.
  - fe and cpu_req in the same cycle while cpu_gnt = 0: the frame wins and cpu_gnt stays 0.
- CLEAR: switch_ram = 1, busy = 1, boid_sel = 0, cpu_gnt = 0; go to READ.
- READ: boid_sel = idx. Capture boid_x/boid_y into internal registers; go to WRITE.
- WRITE:
  - disp_addr = y*VIDEO_WIDTH + x, computed as (y<<9)+(y<<7)+x, zero-extended to ADDR_WIDTH, no truncation.
  - disp_we = 1 only if x < VIDEO_WIDTH and y < VIDEO_HEIGHT. Out-of-range boids are skipped: disp_we = 0, disp_addr is still driven.
  - If idx == MAX_BOIDS-1: go to DONE. Otherwise idx+1 and go to READ.
- DONE: frame_done = 1, busy = 0; go to IDLE.
- Timing: fe sampled at cycle t → CLEAR at t+1 → first WRITE at t+3 → last WRITE at t+2*MAX_BOIDS+1 → frame_done at t+2*MAX_BOIDS+2. busy is high from t+1 to t+2*MAX_BOIDS+1.
- fe while busy: ignored (no restart); overrun set to 1 until reset.
- A pending frame starts in the cycle after cpu_gnt falls. At most one pending frame is held; a second fe while pending also sets overrun.
- cpu_gnt is 0 in every state except IDLE. cpu_req dropping clears cpu_gnt on the next cycle.
- Reset asserted mid-scan: on the next edge, return to IDLE with all outputs at reset values; no partial write follows.
- enable = 0 while pending = 1: pending is kept.

Optional Feature:
- Macro: BOID_FRAME_STATS_EN.
- Defined: adds output dropped_frames [15:0], a saturating count of every fe that sets overrun, cleared by reset.
- Not defined: the port is absent; overrun behaviour is unchanged.

Test Plan:
- Frame scan: MAX_BOIDS=4; boids at (10,10), (0,0), (639,479), (5,1); screen_end rises at t → switch_ram at t+1; disp_we at t+3, t+5, t+7, t+9 with disp_addr 6410, 0, 307199, 645; frame_done at t+10.
- Out of range: boid 2 at (640,0) → disp_we stays 0 in that WRITE cycle; the other three writes occur; frame_done still at t+10.
- Frame during CPU grant: cpu_req=1 (cpu_gnt=1), then screen_end rises → no switch_ram. Drop cpu_req at cycle u → cpu_gnt=0 at u+1, switch_ram at u+2.
- Overrun: second screen_end rise at t+4 → scan unchanged, frame_done at t+10, overrun=1 and stays 1. With BOID_FRAME_STATS_EN defined, dropped_frames=1.
- Reset mid-scan: reset=0 at t+5 → from t+6 busy=0, disp_we=0, boid_sel=0. screen_end still high after reset release → no scan until a new rising edge.
- Long screen_end: held high for 20 cycles → exactly one scan, overrun stays 0.
